// File: rtl/memory_stream_reader_if.sv
// Memory read port plus downstream valid/ready stream of the memory stream reader.
interface memory_stream_reader_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic [BUS_WIDTH-1:0]  memAddr;
  logic [DATA_WIDTH-1:0] memReadData;
  logic [DATA_WIDTH-1:0] outData;
  logic                  outValid;
  logic                  outReady;

  modport master (output memAddr, outData, outValid, input memReadData, outReady);
  modport slave  (input memAddr, outData, outValid, output memReadData, outReady);
endinterface

// File: rtl/memory_stream_reader.sv
// Walks a contiguous word window of a combinational-read memory and streams the
// words out through a 2-entry FIFO so reads stall cleanly under backpressure.
module memory_stream_reader #(
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] baseAddr,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  output logic                   busy,
  output logic                   done,
  memory_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] cur_addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0]  fifo_q [2];
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             count;
  logic                   push, pop;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = (count != 2'd0) && bus.outReady;
    case (state)
      IDLE:  if (start) state_nxt = (wordCount != '0) ? READ : DONE;
      READ: begin
        push = (count < 2'd2) || pop;
        if (push && remaining == COUNT_WIDTH'(1)) state_nxt = DRAIN;
      end
      DRAIN: if (count == 2'd0 || (count == 2'd1 && pop)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cur_addr  <= baseAddr;
        remaining <= wordCount;
      end
      if (push) begin
        fifo_q[wr_ptr] <= bus.memReadData;
        wr_ptr         <= ~wr_ptr;
        remaining      <= remaining - COUNT_WIDTH'(1);
        // Final address is held so memAddr shows the last issued index in DRAIN.
        if (remaining != COUNT_WIDTH'(1)) cur_addr <= cur_addr + INDEX_WIDTH'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.memAddr  = {{(BUS_WIDTH-INDEX_WIDTH){1'b0}}, cur_addr};
  assign bus.outData  = fifo_q[rd_ptr];
  assign bus.outValid = (count != 2'd0);
  assign busy         = (state == READ) || (state == DRAIN);
  assign done         = (state == DONE);
endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed and randomized runs of memory_stream_reader against a queue-based model.
module tb_memory_stream_reader;
  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] baseAddr;
  logic [15:0] wordCount;
  logic        busy, done;
  logic [31:0] mem [65536];
  int          nvec = 0;
  int          nerr = 0;

  memory_stream_reader_if bus ();

  memory_stream_reader dut (
    .CLK(CLK), .reset(reset), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .busy(busy), .done(done), .bus(bus)
  );

  always #5 CLK = ~CLK;
  assign bus.memReadData = mem[bus.memAddr[15:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // rmode: 0 always ready, 1 ready 1,0,0 repeating, 2 random, 3 stalled 3 cycles then ready
  task automatic run(input logic [15:0] base, input logic [15:0] cnt, input int rmode,
                     input int abort_after, input bit extra_start);
    logic [31:0] exp_q [$];
    logic [31:0] prev_d;
    logic [15:0] off, ea;
    int          got, cyc;
    bit          fin, stalled;
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(mem[16'(base + 16'(i))]);
    @(negedge CLK);
    start = 1'b1; baseAddr = base; wordCount = cnt; bus.outReady = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1; got = 0; fin = 0; stalled = 0; prev_d = '0;
    while (!fin && cyc < 400) begin
      if (abort_after >= 0 && got == abort_after) begin
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        chk("rst_valid", {31'b0, bus.outValid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_addr", bus.memAddr, 32'd0);
        repeat (3) begin
          @(negedge CLK);
          chk("post_rst_valid", {31'b0, bus.outValid}, 32'd0);
          chk("post_rst_done", {31'b0, done}, 32'd0);
        end
        return;
      end
      if (extra_start && cyc == 2) begin
        start = 1'b1; baseAddr = base + 16'd100; wordCount = 16'd1;
      end else start = 1'b0;
      case (rmode)
        0: bus.outReady = 1'b1;
        1: bus.outReady = (cyc % 3 == 1);
        2: bus.outReady = 1'($urandom_range(0, 1));
        default: bus.outReady = (cyc > 3);
      endcase
      if (stalled) begin
        chk("stall_valid", {31'b0, bus.outValid}, 32'd1);
        chk("stall_data", bus.outData, prev_d);
      end
      if (done) begin
        chk("done_words", got, int'(cnt));
        chk("done_busy", {31'b0, busy}, 32'd0);
        if (rmode == 0) chk("done_latency", cyc, int'(cnt) + 2);
        fin = 1;
      end else begin
        chk("busy", {31'b0, busy}, 32'd1);
        off = bus.memAddr[15:0] - base;
        chk("ahead", {31'b0, (int'(off) <= got + 2)}, 32'd1);
        if (rmode == 0 && cyc <= int'(cnt)) begin
          ea = base + 16'(cyc - 1);
          chk("addr_seq", bus.memAddr, {16'h0, ea});
        end
        if (rmode == 0 && cyc == 1) chk("first_invalid", {31'b0, bus.outValid}, 32'd0);
        if (rmode == 0 && cyc == 2) chk("first_valid", {31'b0, bus.outValid}, 32'd1);
        if (bus.outValid && bus.outReady) begin
          if (got < int'(cnt)) chk("data", bus.outData, exp_q[got]);
          else chk("extra_word", got, int'(cnt) - 1);
          got++;
        end
      end
      stalled = bus.outValid && !bus.outReady;
      prev_d  = bus.outData;
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 32'd0, 32'd1);
    else begin
      chk("done_pulse_len", {31'b0, done}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_valid", {31'b0, bus.outValid}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; baseAddr = '0; wordCount = '0; bus.outReady = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i * 3);
    repeat (2) @(negedge CLK);
    chk("reset_valid", {31'b0, bus.outValid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_addr", bus.memAddr, 32'd0);
    chk("reset_data", bus.outData, 32'd0);
    reset = 1'b0;

    run(16'd10, 16'd4, 0, -1, 1'b0);
    run(16'd0, 16'd5, 1, -1, 1'b0);

    @(negedge CLK);
    start = 1'b1; baseAddr = 16'd5; wordCount = 16'd0;
    @(negedge CLK);
    start = 1'b0;
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    chk("zero_valid", {31'b0, bus.outValid}, 32'd0);
    @(negedge CLK);
    chk("zero_done_end", {31'b0, done}, 32'd0);
    chk("zero_busy_end", {31'b0, busy}, 32'd0);
    chk("zero_valid_end", {31'b0, bus.outValid}, 32'd0);

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    run(16'hFFFE, 16'd4, 0, -1, 1'b0);
    run(16'd20, 16'd6, 0, -1, 1'b1);
    run(16'd40, 16'd6, 0, 3, 1'b0);
    run(16'd50, 16'd3, 0, -1, 1'b0);
    run(16'd60, 16'd5, 3, -1, 1'b0);
    for (int k = 0; k < 8; k++)
      run(16'($urandom), 16'($urandom_range(1, 12)), 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
